enc_link_ctrl: RTL

ENC_LINK_CTRL -- requirements
Module: enc_link_ctrl

---
 rtl/enc_link_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/enc_link_ctrl.sv
// ---------------------------------------------------------------------------
// enc_link_ctrl
// Link-layer front end for an external combinational 8b/10b encoder.
// After enable it sends ALIGN_CNT K28.5 commas, then passes source bytes
// through. It forces an idle comma cycle plus one SKIP comma whenever
// SKIP_PERIOD data bytes have been sent back to back. The encoder result
// is registered onto the line, and the running disparity is tracked from
// the popcount of each registered symbol.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   en                  link enable
//   in_valid/in_ready   source handshake (in_ready is combinational)
//   in_data, in_k       source byte and its control flag
//   enc_data, enc_k     byte and control flag presented to the encoder
//   enc_rd              running disparity presented to the encoder
//   enc_sym             encoder result, same cycle
//   tx_sym, tx_valid    registered line symbol and its valid flag
//   rd_state            current running disparity (0 = RD-, 1 = RD+)
//   aligned             alignment sequence complete, RUN entered
// ---------------------------------------------------------------------------
module enc_link_ctrl #(
  parameter int          ALIGN_CNT   = 16,
  parameter int          SKIP_PERIOD = 256,
  parameter logic [7:0]  IDLE_K      = 8'hBC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_k,
  output logic [7:0]  enc_data,
  output logic        enc_k,
  output logic        enc_rd,
  input  logic [9:0]  enc_sym,
  output logic [9:0]  tx_sym,
  output logic        tx_valid,
  output logic        rd_state,
  output logic        aligned
);

  localparam int AW = $clog2(ALIGN_CNT + 1);
  localparam int SW = $clog2(SKIP_PERIOD + 1);

  typedef enum logic [1:0] {OFF, ALIGN, RUN, SKIP} state_t;

  state_t         state;
  logic [AW-1:0]  align_cnt;
  logic [SW-1:0]  skip_cnt;
  logic [AW-1:0]  align_nxt;
  logic           xfer;

  // Saturating increments: counters stop at their parameter value.
  function automatic logic [AW-1:0] align_sat_inc(input logic [AW-1:0] c);
    return (c == AW'(ALIGN_CNT)) ? c : c + AW'(1);
  endfunction

  function automatic logic [SW-1:0] skip_sat_inc(input logic [SW-1:0] c);
    return (c == SW'(SKIP_PERIOD)) ? c : c + SW'(1);
  endfunction

  // Disparity after a symbol: heavy symbols leave RD+, light ones RD-,
  // balanced symbols keep the current disparity.
  function automatic logic rd_after(input logic [9:0] sym, input logic rd);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 10; i++) ones = ones + {3'b000, sym[i]};
    if (ones > 4'd5)      return 1'b1;
    else if (ones < 4'd5) return 1'b0;
    else                  return rd;
  endfunction

  // Readiness drops the same cycle en falls or the run limit is reached.
  assign in_ready  = en && (state == RUN) && (skip_cnt < SW'(SKIP_PERIOD));
  assign xfer      = in_valid && in_ready;
  assign enc_rd    = rd_state;
  assign align_nxt = align_sat_inc(align_cnt);

  // Anything that is not an accepted byte is an idle comma.
  always_comb begin
    enc_data = IDLE_K;
    enc_k    = 1'b1;
    if (xfer) begin
      enc_data = in_data;
      enc_k    = in_k;
    end
  end

  // Line register stage: encoder output captured, disparity advanced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      tx_sym    <= 10'h000;
      tx_valid  <= 1'b0;
      rd_state  <= 1'b0;
      aligned   <= 1'b0;
      align_cnt <= '0;
      skip_cnt  <= '0;
    end else if (state == OFF) begin
      tx_valid  <= 1'b0;
      align_cnt <= '0;
      skip_cnt  <= '0;
      if (en) state <= ALIGN;
    end else if (!en) begin
      // Leaving the link: no symbol this edge, tx_sym and rd_state hold.
      state     <= OFF;
      tx_valid  <= 1'b0;
      aligned   <= 1'b0;
      align_cnt <= '0;
      skip_cnt  <= '0;
    end else begin
      tx_sym   <= enc_sym;
      tx_valid <= 1'b1;
      rd_state <= rd_after(enc_sym, rd_state);
      case (state)
        ALIGN: begin
          align_cnt <= align_nxt;
          if (align_nxt == AW'(ALIGN_CNT)) begin
            state   <= RUN;
            aligned <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) skip_cnt <= skip_sat_inc(skip_cnt);
          else      skip_cnt <= '0;
          if (skip_cnt == SW'(SKIP_PERIOD)) state <= SKIP;
        end
        SKIP: begin
          skip_cnt <= '0;
          state    <= RUN;
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule
